// File: rtl/watch_time_counter_pkg.sv
// Shared watch encodings (set position, mode), BCD wrap constants and BCD helpers.
// Must stay in step with the encodings used by the clock/select block.
package watch_time_counter_pkg;

   localparam logic [2:0] POSITION_HOUR   = 3'b100;
   localparam logic [2:0] POSITION_MINUTE = 3'b010;
   localparam logic [2:0] POSITION_SECOND = 3'b001;
   localparam logic [2:0] POSITION_NONE   = 3'b000;

   localparam logic MODE_NORMAL  = 1'b0;
   localparam logic MODE_SETTING = 1'b1;

   localparam logic [7:0] BCD_WRAP_59 = 8'h59;

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
   } watch_time_t;

   // Per-digit BCD increment; callers handle the full-byte wrap before this is used.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] int_to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/watch_time_counter_debounce.sv
// watch_debounce: 2-FF synchroniser, stable-sample counter and rising-edge pulse
// for a bouncing push-button. Reusable for any of the watch buttons.
module watch_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;

   // The counter only advances while the synced input disagrees with the accepted
   // level; any sample that agrees again restarts the stability window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync    <= 2'b00;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_level_d <= r_level;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/watch_time_counter.sv
// Watch timekeeping: HH:MM:SS packed-BCD counter with 1 Hz tick, setting mode and
// debounced increment. Optional field blinking is built when WATCH_BLINK_EN is defined.
module watch_time_counter
   import watch_time_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int HOUR_MAX        = 23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk1hz_in,
   input  logic       clk2hz_in,
   input  logic       mode_in,
   input  logic [2:0] set_pos_in,
   input  logic       sw_inc,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [2:0] blank_out
);

   localparam logic [7:0] HOUR_WRAP = int_to_bcd(HOUR_MAX);

   logic [1:0]  r_1hz_s;
   logic        r_1hz_d;
   logic [1:0]  r_mode_s;
   logic [2:0]  r_pos_s1;
   logic [2:0]  r_pos_s2;
   watch_time_t r_time;

   logic        w_tick;
   logic        w_inc;
   logic        w_inc_level;
   logic        w_setting;
   watch_time_t w_time_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_1hz_s  <= 2'b00;
         r_1hz_d  <= 1'b0;
         r_mode_s <= 2'b00;
         r_pos_s1 <= 3'b000;
         r_pos_s2 <= 3'b000;
      end else begin
         r_1hz_s  <= {r_1hz_s[0], clk1hz_in};
         r_1hz_d  <= r_1hz_s[1];
         r_mode_s <= {r_mode_s[0], mode_in};
         r_pos_s1 <= set_pos_in;
         r_pos_s2 <= r_pos_s1;
      end
   end

   assign w_tick    = r_1hz_s[1] & ~r_1hz_d;
   assign w_setting = (r_mode_s[1] == MODE_SETTING);

   watch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_inc_debounce (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (sw_inc),
      .o_level(w_inc_level),
      .o_rise (w_inc)
   );

   // Normal mode ripples the carry through all three fields in one cycle;
   // setting mode bumps only the selected field and never carries.
   always_comb begin
      w_time_nxt = r_time;
      if (!w_setting) begin
         if (w_tick) begin
            if (r_time.sec == BCD_WRAP_59) begin
               w_time_nxt.sec = 8'h00;
               if (r_time.min == BCD_WRAP_59) begin
                  w_time_nxt.min  = 8'h00;
                  w_time_nxt.hour = (r_time.hour == HOUR_WRAP) ? 8'h00 : bcd_inc(r_time.hour);
               end else begin
                  w_time_nxt.min = bcd_inc(r_time.min);
               end
            end else begin
               w_time_nxt.sec = bcd_inc(r_time.sec);
            end
         end
      end else if (w_inc) begin
         case (r_pos_s2)
            POSITION_HOUR:
               w_time_nxt.hour = (r_time.hour == HOUR_WRAP) ? 8'h00 : bcd_inc(r_time.hour);
            POSITION_MINUTE:
               w_time_nxt.min = (r_time.min == BCD_WRAP_59) ? 8'h00 : bcd_inc(r_time.min);
            POSITION_SECOND:
               w_time_nxt.sec = (r_time.sec == BCD_WRAP_59) ? 8'h00 : bcd_inc(r_time.sec);
            POSITION_NONE: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_time <= '0;
      else
         r_time <= w_time_nxt;
   end

   assign hour_bcd = r_time.hour;
   assign min_bcd  = r_time.min;
   assign sec_bcd  = r_time.sec;

`ifdef WATCH_BLINK_EN
   logic [1:0] r_2hz_s;
   logic [2:0] w_blank;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_2hz_s <= 2'b00;
      else
         r_2hz_s <= {r_2hz_s[0], clk2hz_in};
   end

   always_comb begin
      w_blank = 3'b000;
      if (w_setting) begin
         case (r_pos_s2)
            POSITION_HOUR, POSITION_MINUTE, POSITION_SECOND:
               w_blank = r_pos_s2 & {3{~r_2hz_s[1]}};
            default: w_blank = 3'b000;
         endcase
      end
   end

   assign blank_out = w_blank;
`else
   logic w_unused_clk2hz;
   assign w_unused_clk2hz = clk2hz_in ^ w_inc_level;
   assign blank_out       = 3'b000;
`endif

endmodule

// File: tb/tb_watch_time_counter.sv
// Self-checking bench for watch_time_counter with a short debounce window.
module tb_watch_time_counter;

   localparam int DEB = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clk1hz_in = 1'b0;
   logic       clk2hz_in = 1'b0;
   logic       mode_in = 1'b0;
   logic [2:0] set_pos_in = 3'b000;
   logic       sw_inc = 1'b0;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic [2:0] blank_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] exp_q[$];

   int         m_h = 0;
   int         m_m = 0;
   int         m_s = 0;
   logic       m_mode = 1'b0;
   logic [2:0] m_pos = 3'b000;

   typedef struct {
      string       name;
      logic        mode;
      logic [2:0]  pos;
      int          act;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[9];

   watch_time_counter #(
      .DEBOUNCE_CYCLES(DEB),
      .HOUR_MAX(23)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk1hz_in (clk1hz_in),
      .clk2hz_in (clk2hz_in),
      .mode_in   (mode_in),
      .set_pos_in(set_pos_in),
      .sw_inc    (sw_inc),
      .hour_bcd  (hour_bcd),
      .min_bcd   (min_bcd),
      .sec_bcd   (sec_bcd),
      .blank_out (blank_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_tick();
      if (m_mode == 1'b0) begin
         if (m_s == 59) begin
            m_s = 0;
            if (m_m == 59) begin
               m_m = 0;
               m_h = (m_h == 23) ? 0 : m_h + 1;
            end else begin
               m_m = m_m + 1;
            end
         end else begin
            m_s = m_s + 1;
         end
      end
   endtask

   task automatic model_press();
      if (m_mode == 1'b1) begin
         case (m_pos)
            3'b100: m_h = (m_h + 1) % 24;
            3'b010: m_m = (m_m + 1) % 60;
            3'b001: m_s = (m_s + 1) % 60;
            default: ;
         endcase
      end
   endtask

   task automatic push_model();
      exp_q.push_back({to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)});
   endtask

   task automatic check_time(input string name);
      logic [23:0] exp;
      logic [23:0] act;
      n_tests++;
      act = {hour_bcd, min_bcd, sec_bcd};
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected value queued, got %h", name, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
         end
      end
   endtask

   task automatic check_blank(input string name, input logic [2:0] exp);
      n_tests++;
      if (blank_out !== exp) begin
         n_fail++;
         $display("FAIL %s: blank_out got %b required %b", name, blank_out, exp);
      end
   endtask

   task automatic apply_mode_pos(input logic m, input logic [2:0] p);
      mode_in    = m;
      set_pos_in = p;
      m_mode     = m;
      m_pos      = p;
      cycles(4);
   endtask

   task automatic do_tick();
      clk1hz_in = 1'b1;
      model_tick();
      cycles(4);
      clk1hz_in = 1'b0;
      cycles(4);
   endtask

   task automatic do_press();
      sw_inc = 1'b1;
      cycles(DEB + 6);
      sw_inc = 1'b0;
      cycles(DEB + 6);
      model_press();
   endtask

   task automatic set_field(input logic [2:0] p, input int target);
      int cur;
      apply_mode_pos(1'b1, p);
      for (int k = 0; k < 70; k++) begin
         cur = (p == 3'b100) ? m_h : (p == 3'b010) ? m_m : m_s;
         if (cur == target) break;
         do_press();
      end
   endtask

   initial begin
      vecs[0] = '{"set_sec",      1'b1, 3'b001, 0, 24'h000001};
      vecs[1] = '{"set_min",      1'b1, 3'b010, 0, 24'h000101};
      vecs[2] = '{"set_hour",     1'b1, 3'b100, 0, 24'h010101};
      vecs[3] = '{"pos_none",     1'b1, 3'b000, 0, 24'h010101};
      vecs[4] = '{"pos_not_1hot", 1'b1, 3'b011, 0, 24'h010101};
      vecs[5] = '{"tick_in_set",  1'b1, 3'b001, 1, 24'h010101};
      vecs[6] = '{"inc_in_norm",  1'b0, 3'b001, 0, 24'h010101};
      vecs[7] = '{"tick_norm_1",  1'b0, 3'b000, 1, 24'h010102};
      vecs[8] = '{"tick_norm_2",  1'b0, 3'b000, 1, 24'h010103};

      // Reset state
      cycles(3);
      exp_q.push_back(24'h000000);
      check_time("reset_state");
      check_blank("reset_blank", 3'b000);
      reset = 1'b1;
      cycles(2);

      // Table-driven single steps
      for (int i = 0; i < 9; i++) begin
         apply_mode_pos(vecs[i].mode, vecs[i].pos);
         exp_q.push_back(vecs[i].exp);
         if (vecs[i].act == 0) do_press();
         else do_tick();
         check_time(vecs[i].name);
      end

      // Preload 23:59:58, then full carry chain wrap
      set_field(3'b100, 23);
      set_field(3'b010, 59);
      set_field(3'b001, 58);
      exp_q.push_back(24'h235958);
      check_time("preload_235958");
      apply_mode_pos(1'b0, 3'b000);
      do_tick();
      push_model();
      check_time("tick_235959");
      clk1hz_in = 1'b1;
      cycles(2);
      exp_q.push_back(24'h235959);
      check_time("before_latency");
      cycles(1);
      model_tick();
      exp_q.push_back(24'h000000);
      check_time("wrap_all_3cyc");
      clk1hz_in = 1'b0;
      cycles(4);

      // Minute wrap in setting mode, no carry
      set_field(3'b001, 5);
      set_field(3'b010, 59);
      do_press();
      exp_q.push_back(24'h000005);
      check_time("min_wrap_nocarry");

      // Bouncing button, then long hold: exactly one increment
      apply_mode_pos(1'b1, 3'b001);
      for (int i = 0; i < 40; i++) begin
         sw_inc = ((i / 3) % 2) == 1;
         cycles(1);
      end
      sw_inc = 1'b1;
      cycles(6 * DEB);
      sw_inc = 1'b0;
      cycles(3 * DEB);
      model_press();
      exp_q.push_back(24'h000006);
      check_time("bounce_one_inc");

      // Frozen in setting mode, resumes from edited value
      for (int i = 0; i < 5; i++) do_tick();
      push_model();
      check_time("frozen_5_ticks");
      apply_mode_pos(1'b0, 3'b000);
      do_tick();
      exp_q.push_back(24'h000007);
      check_time("resume_count");

      // Blink
      apply_mode_pos(1'b1, 3'b100);
      clk2hz_in = 1'b0;
      cycles(4);
`ifdef WATCH_BLINK_EN
      check_blank("blink_low", 3'b100);
`else
      check_blank("blink_low", 3'b000);
`endif
      clk2hz_in = 1'b1;
      cycles(4);
      check_blank("blink_high", 3'b000);
      clk2hz_in = 1'b0;
      apply_mode_pos(1'b0, 3'b000);
      check_blank("blink_normal", 3'b000);

      // Asynchronous reset mid-count at 12:34:56
      set_field(3'b100, 12);
      set_field(3'b010, 34);
      set_field(3'b001, 56);
      exp_q.push_back(24'h123456);
      check_time("preload_123456");
      apply_mode_pos(1'b0, 3'b000);
      clk1hz_in = 1'b1;
      cycles(1);
      #2;
      reset = 1'b0;
      #1;
      exp_q.push_back(24'h000000);
      check_time("async_reset");
      check_blank("async_reset_blank", 3'b000);
      clk1hz_in = 1'b0;
      cycles(3);
      reset = 1'b1;
      m_h = 0; m_m = 0; m_s = 0;
      cycles(6);
      push_model();
      check_time("after_reset_no_pending");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
